pr_region_ctrl: RTL and testbench
=================================

# pr_region_ctrl

Reconfiguration sequencer for one partially reconfigurable region of the RCA. It accepts a request to swap the region to a new bitstream, then drains operations already in flight and decouples the region. It drives the configuration loader, holds the region in reset, and then releases it. It sits between the RCA issue/writeback logic, which observes its stall and decouple outputs, and the shared configuration-port manager.

## Interface
Parameters:
- ID_W, 3: bitstream id width.
- INFL_W, 4: in-flight counter width; max outstanding = 2^INFL_W-1.
- RST_HOLD_CYCLES, 4: region reset hold length, ≥1.
- BOOT_VALID, 1: region holds a valid static configuration after reset.
- BOOT_ID, 0: id of the boot configuration.
- TIMEOUT_CYCLES, 1024: load timeout (used only with the macro).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- reconf_req  in  1  reconfiguration request; held until ack.
- reconf_id  in  ID_W  requested bitstream id.
- reconf_ack  out  1  request accepted this cycle.
- reconf_done  out  1  one-cycle pulse: region live with requested id.
- reconf_err  out  1  one-cycle pulse: load failed or timed out.
- busy  out  1  sequencer not in IDLE.
- current_id  out  ID_W  id currently loaded.
- config_valid  out  1  region holds a usable configuration.
- issue  in  1  operand pair accepted into region.
- retire  in  1  region result consumed.
- issue_stall  out  1  upstream must not issue.
- decouple  out  1  gate region valids in/out.
- region_rst  out  1  reset to the region logic.
- cfg_load_req  out  1  load request to config manager (level).
- cfg_load_id  out  ID_W  bitstream to load.
- cfg_load_done  in  1  load complete pulse.
- cfg_load_err  in  1  load failed pulse.

## Operation
- The block tracks in-flight operations in a counter.
  - issue&!retire increments the counter; retire&!issue decrements it; issue&retire leaves it unchanged.
  - retire at 0 is ignored.
  - issue at max count is ignored and the counter saturates.
- The state machine has four states: IDLE, DRAIN, LOAD_WAIT, RST_HOLD.
- IDLE:
  - reconf_ack = reconf_req (combinational).
  - On accept with reconf_id==current_id and config_valid: stay in IDLE and pulse reconf_done next cycle. No reload occurs.
  - Otherwise latch the id into cfg_load_id and go to DRAIN.
- DRAIN:
  - issue_stall=1 and decouple=0, so in-flight work completes.
  - When the counter is 0 and issue is low, go to LOAD_WAIT.
- LOAD_WAIT:
  - decouple=1, region_rst=1, cfg_load_req=1, config_valid=0.
  - cfg_load_done: current_id←latched id, config_valid←1, go to RST_HOLD.
  - cfg_load_err: pulse reconf_err, go to IDLE with config_valid=0.
  - If done and err arrive in the same cycle, err wins.
- RST_HOLD:
  - region_rst=1 and decouple=1 for exactly RST_HOLD_CYCLES cycles.
  - Then go to IDLE and pulse reconf_done.
- In IDLE, the outputs follow config_valid:
  - decouple = region_rst = issue_stall = !config_valid.
- Requests are never acked outside IDLE.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, counter 0, current_id=BOOT_ID, config_valid=BOOT_VALID.
  - decouple = region_rst = issue_stall = !BOOT_VALID.
  - cfg_load_req=0, reconf_ack=0 (req low), reconf_done=0, reconf_err=0, busy=0.
- Full reload cycle sequence:
  - Accept at cycle T.
  - DRAIN from T+1; issue_stall high from T+1.
  - With an empty counter, LOAD_WAIT and cfg_load_req start at T+2.
  - cfg_load_done at cycle D gives RST_HOLD over D+1..D+R, where R = RST_HOLD_CYCLES.
  - IDLE at D+R+1, with reconf_done high, decouple and issue_stall low.
- Same-id request: ack at T, reconf_done at T+1, no other output changes.
- cfg_load_req drops in the cycle after done, err or timeout.
- The config manager must tolerate req staying high through the done cycle.
- Reset asserted mid-operation returns to the reset values immediately and asynchronously. The loader sees req drop; a partially loaded region is covered only if BOOT_VALID=0.

## Configuration
- RCA_PR_TIMEOUT_EN defined:
  - A counter runs in LOAD_WAIT, cleared on entry.
  - If TIMEOUT_CYCLES cycles pass without done or err, the block behaves as cfg_load_err: reconf_err pulse, config_valid=0, IDLE.
- RCA_PR_TIMEOUT_EN undefined: LOAD_WAIT waits indefinitely and no counter is built.

## Test plan
- Reset with BOOT_VALID=1, BOOT_ID=2, then req id=2 → ack at T, reconf_done at T+1, cfg_load_req never asserted.
- Three issues, then req id=5 → DRAIN holds with decouple=0 until three retires. cfg_load_req rises 1 cycle after the counter reaches 0. done at D → current_id=5 at D+1, region_rst high D+1..D+4, reconf_done at D+5.
- Simultaneous issue+retire during DRAIN with count 1 → count stays 1 and the sequencer stays in DRAIN. A lone retire then advances it.
- cfg_load_err in LOAD_WAIT → reconf_err pulse, config_valid=0, decouple and issue_stall stay high in IDLE. Next req id=1 with load success → config_valid=1.
- With RCA_PR_TIMEOUT_EN and TIMEOUT_CYCLES=16, no done → reconf_err 16 cycles after LOAD_WAIT entry, cfg_load_req low the cycle after.
- rst asserted in RST_HOLD → all outputs take reset values immediately, busy=0.

Source files
------------

// File: rtl/pr_region_ctrl.sv
// Reconfiguration sequencer for one partially reconfigurable RCA region: drain, load, reset-hold, release.
// Optional load timeout is built when RCA_PR_TIMEOUT_EN is defined.
module pr_region_ctrl #(
  parameter int ID_W            = 3,
  parameter int INFL_W          = 4,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int BOOT_VALID      = 1,
  parameter int BOOT_ID         = 0,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reconf_req,
  input  logic [ID_W-1:0] reconf_id,
  output logic            reconf_ack,
  output logic            reconf_done,
  output logic            reconf_err,
  output logic            busy,
  output logic [ID_W-1:0] current_id,
  output logic            config_valid,
  input  logic            issue,
  input  logic            retire,
  output logic            issue_stall,
  output logic            decouple,
  output logic            region_rst,
  output logic            cfg_load_req,
  output logic [ID_W-1:0] cfg_load_id,
  input  logic            cfg_load_done,
  input  logic            cfg_load_err
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_LOAD_WAIT = 2'd2,
    ST_RST_HOLD  = 2'd3
  } state_t;

  localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [INFL_W-1:0] INFL_MAX  = {INFL_W{1'b1}};
  localparam logic [INFL_W-1:0] INFL_ZERO = {INFL_W{1'b0}};
  localparam logic [INFL_W-1:0] INFL_ONE  = INFL_W'(1);
  localparam logic              BOOT_VLD  = (BOOT_VALID != 0);
  localparam logic [ID_W-1:0]   BOOT_IDV  = ID_W'(BOOT_ID);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [INFL_W-1:0] infl_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_nxt_s;
  logic              valid_nxt_s;
  logic [ID_W-1:0]   id_nxt_s;
  logic [ID_W-1:0]   load_id_nxt_s;
  logic              done_nxt_s;
  logic              err_nxt_s;
  logic              decouple_nxt_s;
  logic              region_rst_nxt_s;
  logic              stall_nxt_s;
  logic              load_req_nxt_s;
  logic              timeout_s;

  assign reconf_ack = reconf_req & (state_r == ST_IDLE);

  // In-flight operation counter: saturates at max, ignores retire at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_r <= INFL_ZERO;
    end else begin
      case ({issue, retire})
        2'b10:   if (infl_r != INFL_MAX)  infl_r <= infl_r + INFL_ONE;
        2'b01:   if (infl_r != INFL_ZERO) infl_r <= infl_r - INFL_ONE;
        default: infl_r <= infl_r;
      endcase
    end
  end

`ifdef RCA_PR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Cycles spent waiting on the loader; restarts from zero on every LOAD_WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_LOAD_WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end else begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end
  end

  assign timeout_s = (state_r == ST_LOAD_WAIT) && (tmo_cnt_r == TMO_LAST);
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES != 0);
  assign timeout_s    = 1'b0;
`endif

  // Next-state, configuration bookkeeping and completion pulses.
  always_comb begin
    state_nxt_s   = state_r;
    valid_nxt_s   = config_valid;
    id_nxt_s      = current_id;
    load_id_nxt_s = cfg_load_id;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;
    hold_nxt_s    = HOLD_ZERO;
    case (state_r)
      ST_IDLE: begin
        if (reconf_req) begin
          if ((reconf_id == current_id) && config_valid) begin
            done_nxt_s = 1'b1;
          end else begin
            load_id_nxt_s = reconf_id;
            state_nxt_s   = ST_DRAIN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if ((infl_r == INFL_ZERO) && !issue) begin
          state_nxt_s = ST_LOAD_WAIT;
          valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_LOAD_WAIT: begin
        // A failure report outranks a completion arriving in the same cycle.
        if (cfg_load_err || timeout_s) begin
          err_nxt_s   = 1'b1;
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_IDLE;
        end else if (cfg_load_done) begin
          id_nxt_s    = cfg_load_id;
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_RST_HOLD;
        end else begin
          state_nxt_s = ST_LOAD_WAIT;
        end
      end
      ST_RST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          hold_nxt_s  = hold_cnt_r + HOLD_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Region-facing controls decoded from the upcoming state so they can be registered.
  always_comb begin
    decouple_nxt_s   = ~valid_nxt_s;
    region_rst_nxt_s = ~valid_nxt_s;
    stall_nxt_s      = ~valid_nxt_s;
    load_req_nxt_s   = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        decouple_nxt_s   = ~valid_nxt_s;
        region_rst_nxt_s = ~valid_nxt_s;
        stall_nxt_s      = ~valid_nxt_s;
      end
      ST_DRAIN: begin
        decouple_nxt_s   = 1'b0;
        region_rst_nxt_s = ~valid_nxt_s;
        stall_nxt_s      = 1'b1;
      end
      ST_LOAD_WAIT: begin
        decouple_nxt_s   = 1'b1;
        region_rst_nxt_s = 1'b1;
        stall_nxt_s      = 1'b1;
        load_req_nxt_s   = 1'b1;
      end
      ST_RST_HOLD: begin
        decouple_nxt_s   = 1'b1;
        region_rst_nxt_s = 1'b1;
        stall_nxt_s      = 1'b1;
      end
      default: begin
        decouple_nxt_s   = 1'b1;
        region_rst_nxt_s = 1'b1;
        stall_nxt_s      = 1'b1;
      end
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= HOLD_ZERO;
      config_valid <= BOOT_VLD;
      current_id   <= BOOT_IDV;
      cfg_load_id  <= BOOT_IDV;
      reconf_done  <= 1'b0;
      reconf_err   <= 1'b0;
      busy         <= 1'b0;
      decouple     <= ~BOOT_VLD;
      region_rst   <= ~BOOT_VLD;
      issue_stall  <= ~BOOT_VLD;
      cfg_load_req <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      hold_cnt_r   <= hold_nxt_s;
      config_valid <= valid_nxt_s;
      current_id   <= id_nxt_s;
      cfg_load_id  <= load_id_nxt_s;
      reconf_done  <= done_nxt_s;
      reconf_err   <= err_nxt_s;
      busy         <= (state_nxt_s != ST_IDLE);
      decouple     <= decouple_nxt_s;
      region_rst   <= region_rst_nxt_s;
      issue_stall  <= stall_nxt_s;
      cfg_load_req <= load_req_nxt_s;
    end
  end

endmodule

// File: tb/tb_pr_region_ctrl.sv
// Scoreboard bench for pr_region_ctrl: stimulus queues expected done/err pulses, a monitor checks them.
module tb_pr_region_ctrl;

  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            reconf_req = 1'b0;
  logic [ID_W-1:0] reconf_id = 3'd0;
  logic            reconf_ack;
  logic            reconf_done;
  logic            reconf_err;
  logic            busy;
  logic [ID_W-1:0] current_id;
  logic            config_valid;
  logic            issue = 1'b0;
  logic            retire = 1'b0;
  logic            issue_stall;
  logic            decouple;
  logic            region_rst;
  logic            cfg_load_req;
  logic [ID_W-1:0] cfg_load_id;
  logic            cfg_load_done = 1'b0;
  logic            cfg_load_err = 1'b0;

  pr_region_ctrl #(
    .ID_W(ID_W), .INFL_W(4), .RST_HOLD_CYCLES(4), .BOOT_VALID(1), .BOOT_ID(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .reconf_req(reconf_req), .reconf_id(reconf_id), .reconf_ack(reconf_ack),
    .reconf_done(reconf_done), .reconf_err(reconf_err), .busy(busy),
    .current_id(current_id), .config_valid(config_valid),
    .issue(issue), .retire(retire), .issue_stall(issue_stall),
    .decouple(decouple), .region_rst(region_rst),
    .cfg_load_req(cfg_load_req), .cfg_load_id(cfg_load_id),
    .cfg_load_done(cfg_load_done), .cfg_load_err(cfg_load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = reconf_done pulse, 2 = reconf_err pulse
  typedef struct {
    int kind;
    int cyc;
    int id;
    int valid;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_current_id", int'(current_id), 2);
    chk("rst_config_valid", int'(config_valid), 1);
    chk("rst_decouple", int'(decouple), 0);
    chk("rst_region_rst", int'(region_rst), 0);
    chk("rst_issue_stall", int'(issue_stall), 0);
    chk("rst_cfg_load_req", int'(cfg_load_req), 0);
    chk("rst_reconf_ack", int'(reconf_ack), 0);
    chk("rst_reconf_done", int'(reconf_done), 0);
    chk("rst_reconf_err", int'(reconf_err), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  task automatic request(input int id);
    reconf_req = 1'b1;
    reconf_id  = 3'(id);
    #1;
    chk("ack_in_idle", int'(reconf_ack), 1);
    tick();
    reconf_req = 1'b0;
  endtask

  // Monitor: every completion/error pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        mon_e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: kind %0d expected at cycle %0d, absent at cycle %0d", mon_e.kind, mon_e.cyc, cyc);
      end
      if (reconf_done || reconf_err) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%0d err=%0d, expected none (cycle %0d)", reconf_done, reconf_err, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("pulse_kind", int'({reconf_err, reconf_done}), mon_e.kind);
          chk("pulse_cycle", cyc, mon_e.cyc);
          chk("pulse_current_id", int'(current_id), mon_e.id);
          chk("pulse_config_valid", int'(config_valid), mon_e.valid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    chk_reset_vals();
    rst = 1'b0;
    tick();

    // Same id as boot configuration: immediate done, no load.
    reconf_req = 1'b1;
    reconf_id  = 3'd2;
    #1;
    chk("same_id_ack", int'(reconf_ack), 1);
    sb_q.push_back('{1, cyc + 1, 2, 1});
    tick();
    reconf_req = 1'b0;
    chk("same_id_no_load", int'(cfg_load_req), 0);
    chk("same_id_not_busy", int'(busy), 0);
    tick();
    chk("same_id_no_load_later", int'(cfg_load_req), 0);

    // Three in flight, then reload to id 5.
    issue = 1'b1;
    tick(3);
    issue = 1'b0;
    request(5);
    chk("drain_stall", int'(issue_stall), 1);
    chk("drain_decouple", int'(decouple), 0);
    chk("drain_region_rst", int'(region_rst), 0);
    chk("drain_busy", int'(busy), 1);
    reconf_req = 1'b1;
    #1;
    chk("no_ack_outside_idle", int'(reconf_ack), 0);
    reconf_req = 1'b0;
    tick(2);
    chk("drain_holds_load", int'(cfg_load_req), 0);
    chk("drain_holds_decouple", int'(decouple), 0);
    retire = 1'b1;
    tick(3);
    retire = 1'b0;
    chk("count_zero_still_drain", int'(cfg_load_req), 0);
    tick();
    chk("load_req_rises", int'(cfg_load_req), 1);
    chk("load_decouple", int'(decouple), 1);
    chk("load_region_rst", int'(region_rst), 1);
    chk("load_config_valid", int'(config_valid), 0);
    chk("load_id", int'(cfg_load_id), 5);
    tick(2);
    cfg_load_done = 1'b1;
    sb_q.push_back('{1, cyc + 5, 5, 1});
    tick();
    cfg_load_done = 1'b0;
    chk("hold_current_id", int'(current_id), 5);
    chk("hold_load_req_drop", int'(cfg_load_req), 0);
    chk("hold_region_rst_1", int'(region_rst), 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("hold_region_rst_n", int'(region_rst), 1);
      chk("hold_decouple_n", int'(decouple), 1);
    end
    tick();
    chk("live_region_rst", int'(region_rst), 0);
    chk("live_decouple", int'(decouple), 0);
    chk("live_stall", int'(issue_stall), 0);
    chk("live_busy", int'(busy), 0);

    // Simultaneous issue+retire in DRAIN keeps count at 1.
    issue = 1'b1;
    tick();
    issue = 1'b0;
    request(3);
    issue  = 1'b1;
    retire = 1'b1;
    tick(2);
    issue  = 1'b0;
    retire = 1'b0;
    chk("both_stay_drain", int'(cfg_load_req), 0);
    tick();
    chk("both_still_drain", int'(cfg_load_req), 0);
    chk("both_busy", int'(busy), 1);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    tick();
    chk("lone_retire_advances", int'(cfg_load_req), 1);
    chk("load_id_3", int'(cfg_load_id), 3);

    // Load error.
    cfg_load_err = 1'b1;
    sb_q.push_back('{2, cyc + 1, 5, 0});
    tick();
    cfg_load_err = 1'b0;
    chk("err_load_req_drop", int'(cfg_load_req), 0);
    chk("err_decouple", int'(decouple), 1);
    chk("err_stall", int'(issue_stall), 1);
    chk("err_region_rst", int'(region_rst), 1);
    chk("err_busy", int'(busy), 0);
    tick();
    chk("err_idle_decouple", int'(decouple), 1);

    // done and err together: err wins.
    request(1);
    tick();
    chk("retry1_load_req", int'(cfg_load_req), 1);
    chk("retry1_load_id", int'(cfg_load_id), 1);
    cfg_load_done = 1'b1;
    cfg_load_err  = 1'b1;
    sb_q.push_back('{2, cyc + 1, 5, 0});
    tick();
    cfg_load_done = 1'b0;
    cfg_load_err  = 1'b0;
    chk("err_wins_valid", int'(config_valid), 0);

    // Successful reload to id 1.
    request(1);
    tick();
    chk("retry2_load_req", int'(cfg_load_req), 1);
    cfg_load_done = 1'b1;
    sb_q.push_back('{1, cyc + 5, 1, 1});
    tick();
    cfg_load_done = 1'b0;
    tick(4);
    chk("recover_valid", int'(config_valid), 1);
    chk("recover_id", int'(current_id), 1);
    chk("recover_stall", int'(issue_stall), 0);

`ifdef RCA_PR_TIMEOUT_EN
    // No loader answer: timeout after 16 LOAD_WAIT cycles.
    request(6);
    tick();
    chk("tmo_load_req", int'(cfg_load_req), 1);
    sb_q.push_back('{2, cyc + 16, 1, 0});
    tick(16);
    chk("tmo_load_req_drop", int'(cfg_load_req), 0);
    chk("tmo_busy", int'(busy), 0);
`endif

    // Reset in RST_HOLD.
    request(4);
    tick();
    chk("rsthold_load_req", int'(cfg_load_req), 1);
    cfg_load_done = 1'b1;
    tick();
    cfg_load_done = 1'b0;
    tick();
    chk("rsthold_region_rst", int'(region_rst), 1);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    tick(2);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", int'(config_valid), 1);
    chk("post_rst_id", int'(current_id), 2);
    chk("post_rst_busy", int'(busy), 0);

    tick(2);
    chk("queue_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
